// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one op in flight, DATAWIDTH+1 cycles accept-to-write (1 on div fast paths).
// in_ready only in IDLE; requests offered while busy stay pending until the unit returns to IDLE.
module muldiv_unit #(
    parameter int DATAWIDTH = 32,
    parameter int REGISTERS = 32,
    parameter int INDEX     = $clog2(REGISTERS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           funct3,
    input  logic [DATAWIDTH-1:0] op_a,
    input  logic [DATAWIDTH-1:0] op_b,
    input  logic [INDEX-1:0]     rd,
    input  logic                 flush,
    output logic                 busy,
    output logic                 werf,
    output logic [INDEX-1:0]     wa,
    output logic [DATAWIDTH-1:0] wd
);
    localparam int W  = DATAWIDTH;
    localparam int CW = $clog2(DATAWIDTH) + 1;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_funct3;
    logic [INDEX-1:0] r_rd;
    logic [W-1:0]     r_opnd;
    logic [2*W-1:0]   r_acc;
    logic             r_neg_lo;
    logic             r_neg_rem;

    logic             w_accept, w_a_sgn, w_b_sgn, w_a_neg, w_b_neg;
    logic [W-1:0]     w_a_mag, w_b_mag, w_fast_res;
    logic             w_div_zero, w_div_ovf;
    logic [W:0]       w_sum, w_rem_sh;
    logic [W-1:0]     w_rem_sub;
    logic             w_ge;
    logic [2*W-1:0]   w_mul_next, w_div_next, w_acc_next, w_prod;
    logic [W-1:0]     w_quot, w_rem, w_result;

    assign in_ready = (r_state == IDLE);
    assign busy     = (r_state != IDLE);
    assign w_accept = in_valid & (r_state == IDLE) & ~flush;

    always_comb begin
        w_a_sgn = 1'b0;
        w_b_sgn = 1'b0;
        case (funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin w_a_sgn = 1'b1; w_b_sgn = 1'b1; end
            3'd2:                   w_a_sgn = 1'b1;
            default:                ;
        endcase
    end

    assign w_a_neg    = w_a_sgn & op_a[W-1];
    assign w_b_neg    = w_b_sgn & op_b[W-1];
    assign w_a_mag    = w_a_neg ? -op_a : op_a;
    assign w_b_mag    = w_b_neg ? -op_b : op_b;
    assign w_div_zero = funct3[2] & (op_b == '0);
    assign w_div_ovf  = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == '1);
    assign w_fast_res = w_div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : MIN_NEG);

    // Multiply: r_acc = {partial high, multiplier shifting out}; divide: r_acc = {remainder, dividend/quotient}.
    assign w_sum      = {1'b0, r_acc[2*W-1:W]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_next = {w_sum, r_acc[W-1:1]};
    assign w_rem_sh   = {r_acc[2*W-1:W], r_acc[W-1]};
    assign w_ge       = (w_rem_sh >= {1'b0, r_opnd});
    assign w_rem_sub  = w_rem_sh[W-1:0] - r_opnd;
    assign w_div_next = {(w_ge ? w_rem_sub : w_rem_sh[W-1:0]), r_acc[W-2:0], w_ge};
    assign w_acc_next = r_funct3[2] ? w_div_next : w_mul_next;

    assign w_prod = r_neg_lo  ? -w_acc_next : w_acc_next;
    assign w_quot = r_neg_lo  ? -w_acc_next[W-1:0] : w_acc_next[W-1:0];
    assign w_rem  = r_neg_rem ? -w_acc_next[2*W-1:W] : w_acc_next[2*W-1:W];

    always_comb begin
        w_result = '0;
        case (r_funct3)
            3'd0:             w_result = w_prod[W-1:0];
            3'd1, 3'd2, 3'd3: w_result = w_prod[2*W-1:W];
            3'd4, 3'd5:       w_result = w_quot;
            default:          w_result = w_rem;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_funct3  <= '0;
            r_rd      <= '0;
            r_opnd    <= '0;
            r_acc     <= '0;
            r_neg_lo  <= 1'b0;
            r_neg_rem <= 1'b0;
            werf      <= 1'b0;
            wa        <= '0;
            wd        <= '0;
        end else begin
            werf <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_funct3  <= funct3;
                        r_rd      <= rd;
                        r_cnt     <= '0;
                        r_neg_lo  <= w_a_neg ^ w_b_neg;
                        r_neg_rem <= w_a_neg;
                        if (funct3[2]) begin
                            r_opnd <= w_b_mag;
                            r_acc  <= {{W{1'b0}}, w_a_mag};
                        end else begin
                            r_opnd <= w_a_mag;
                            r_acc  <= {{W{1'b0}}, w_b_mag};
                        end
                        if (w_div_zero | w_div_ovf) begin
                            r_state <= DONE;
                            werf    <= (rd != '0);
                            wa      <= rd;
                            wd      <= w_fast_res;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush) begin
                        r_state <= IDLE;
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == CW'(W-1)) begin
                            r_state <= DONE;
                            werf    <= (r_rd != '0);
                            wa      <= r_rd;
                            wd      <= w_result;
                        end
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
    localparam int W = 32;
    localparam logic [31:0] MINV = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic [4:0]  rd = '0;
    logic        in_ready, busy, werf;
    logic [4:0]  wa;
    logic [31:0] wd;

    muldiv_unit #(.DATAWIDTH(32), .REGISTERS(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .rd(rd), .flush(flush),
        .busy(busy), .werf(werf), .wa(wa), .wd(wd)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
        int          due;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference result straight from the RV32M definitions using 64-bit integer arithmetic.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sbv, ua, ub;
        logic [63:0] p;
        sa  = $signed(a);
        sbv = $signed(b);
        ua  = longint'({32'b0, a});
        ub  = longint'({32'b0, b});
        case (f)
            3'd0: begin p = sa * sbv; return p[31:0]; end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin if (b == 0) return '1; p = sa / sbv; return p[31:0]; end
            3'd5: begin if (b == 0) return '1; p = ua / ub;  return p[31:0]; end
            3'd6: begin if (b == 0) return a;  p = sa % sbv; return p[31:0]; end
            default: begin if (b == 0) return a; p = ua % ub; return p[31:0]; end
        endcase
    endfunction

    // Monitor: every write pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (werf) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_werf: got write wa=%0d wd=%0h want no write (cycle %0d)", wa, wd, cyc);
            end else begin
                e = sb.pop_front();
                check("wa", 64'(wa), 64'(e.rd));
                check("wd", 64'(wd), 64'(e.wd));
                check("werf_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Holds the request until in_ready, records the accept cycle, and queues the expected write.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] r, input logic [31:0] expv, input bit push, output int acc);
        int n;
        bit fast;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1; funct3 = f; op_a = a; op_b = b; rd = r;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles, want 1", n);
            in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc  = cyc + 1;
        fast = f[2] && (b == 0 || (!f[0] && a == MINV && b == 32'hFFFF_FFFF));
        if (push && r != 0) sb.push_back('{r, expv, acc + (fast ? 0 : W)});
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", 64'(in_ready), 64'(1));
    endtask

    logic [2:0]  dir_f [14] = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7,
                                3'd4, 3'd7, 3'd4, 3'd6, 3'd5, 3'd6};
    logic [31:0] dir_a [14] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100,
                                32'd55, 32'h1234, MINV, MINV, 32'd9, 32'hFFFF_FFF9};
    logic [31:0] dir_b [14] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                                32'd2, 32'd2, 32'd7, 32'd7,
                                32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] dir_e [14] = '{32'hFFFF_FFEB, 32'hFFFF_FFFE, 32'h0, 32'hFFFF_FFFF,
                                32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2,
                                32'hFFFF_FFFF, 32'h1234, MINV, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9};

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation still running at time %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int acc, acc2;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [4:0]  r;

        repeat (3) @(negedge clk);
        check("rst_werf", 64'(werf), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_wa", 64'(wa), 64'(0));
        check("rst_wd", 64'(wd), 64'(0));
        rst_n = 1'b1;

        issue(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b1, acc);
        check("busy_in_calc", 64'(busy), 64'(1));
        check("ready_in_calc", 64'(in_ready), 64'(0));
        repeat (33) @(negedge clk);
        check("busy_after_done", 64'(busy), 64'(0));

        for (int i = 0; i < 14; i++) begin
            issue(dir_f[i], dir_a[i], dir_b[i], 5'(i + 1), dir_e[i], 1'b1, acc);
            check("model_vs_table", 64'(model(dir_f[i], dir_a[i], dir_b[i])), 64'(dir_e[i]));
        end
        wait_idle();

        // Flush in the 10th CALC cycle: no write, ready again next cycle, unit still usable.
        issue(3'd0, 32'd5, 32'd6, 5'd9, 32'd30, 1'b0, acc);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("ready_after_flush", 64'(in_ready), 64'(1));
        check("busy_after_flush", 64'(busy), 64'(0));
        issue(3'd0, 32'd3, 32'd4, 5'd7, 32'd12, 1'b1, acc);
        wait_idle();

        // rd=0: DONE cycle still happens but without a write pulse.
        issue(3'd0, 32'd3, 32'd3, 5'd0, 32'd9, 1'b0, acc);
        repeat (32) @(negedge clk);
        check("rd0_done_busy", 64'(busy), 64'(1));
        check("rd0_werf", 64'(werf), 64'(0));
        @(negedge clk);
        check("rd0_idle", 64'(busy), 64'(0));

        // Asynchronous reset in mid-CALC discards the op.
        issue(3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 5'd11, 32'd0, 1'b0, acc);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_werf", 64'(werf), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_ready", 64'(in_ready), 64'(1));
        check("midrst_wa", 64'(wa), 64'(0));
        check("midrst_wd", 64'(wd), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;

        // Request held while busy: accepted exactly once, on the cycle after DONE.
        issue(3'd5, 32'd1000, 32'd33, 5'd12, model(3'd5, 32'd1000, 32'd33), 1'b1, acc);
        issue(3'd6, 32'hFFFF_FC18, 32'd33, 5'd13, model(3'd6, 32'hFFFF_FC18, 32'd33), 1'b1, acc2);
        check("held_accept_spacing", 64'(acc2 - acc), 64'(34));

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom_range(0, 7));
            r = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = 32'd0; end
                2: begin a = MINV; b = 32'hFFFF_FFFF; end
                3: begin a = 32'($urandom_range(0, 1000)); b = 32'($urandom_range(1, 50)); end
                default: begin a = $urandom; b = 32'd0 - 32'($urandom_range(1, 9)); end
            endcase
            issue(f, a, b, r, model(f, a, b), 1'b1, acc);
        end
        wait_idle();
        repeat (5) @(negedge clk);
        check("pending_writes", 64'(sb.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
